text_console: RTL

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/console_pkg.sv | 17 +
 rtl/text_console_if.sv | 10 +
 rtl/console_cursor.sv | 59 +++++
 rtl/text_console.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// console_pkg: shared defaults, state encoding, control codes and cell-address helper for text_console
// No ports; imported by console_cursor and text_console.
package console_pkg;
  localparam int COLS_DEF = 60;
  localparam int ROWS_DEF = 17;
  localparam logic [7:0] BLANK_DEF = 8'h20;
  localparam int VRAM_AW = 10;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_DEL = 8'h7F;
  typedef enum logic [2:0] {INIT_CLR, IDLE, PUT, SCR_RD, SCR_WR, ROW_CLR, FULL_CLR} state_t;
  function automatic logic [VRAM_AW-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col, input int cols);
    return VRAM_AW'(row) * VRAM_AW'(cols) + VRAM_AW'(col);
  endfunction
endpackage

// File: rtl/text_console_if.sv
// text_console_if: character stream handshake into the console
// Signals: ch_valid (source offers), ch_data (8-bit code), ch_ready (console accepts).
// Modports: master = character source, slave = console.
interface text_console_if;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;
  modport master (output ch_valid, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/console_cursor.sv
// console_cursor: text cursor column/row registers with advance, newline, CR, backspace and home commands
// Ports: PixelClk clock, nRST sync active-low reset; adv_i/nl_i/cr_i/bs_i/home_i one-cycle commands;
//        col_o/row_o cursor position; ovf_o high when the command in flight runs past the last row.
// Macro TEXT_CONSOLE_SCROLL_EN: overflow keeps the cursor on the last row (screen scrolls) instead of wrapping to row 0.
module console_cursor import console_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       adv_i,
  input  logic       nl_i,
  input  logic       cr_i,
  input  logic       bs_i,
  input  logic       home_i,
  output logic [5:0] col_o,
  output logic [4:0] row_o,
  output logic       ovf_o
);
  logic [5:0] col_q, col_d;
  logic [4:0] row_q, row_d, nl_row;
  logic       last_col, last_row, newline;
  assign last_col = col_q == 6'(COLS - 1);
  assign last_row = row_q == 5'(ROWS - 1);
  assign newline  = nl_i || (adv_i && last_col);
`ifdef TEXT_CONSOLE_SCROLL_EN
  assign nl_row = last_row ? row_q : row_q + 5'd1;
`else
  assign nl_row = last_row ? 5'd0 : row_q + 5'd1;
`endif
  assign ovf_o = last_row && newline;
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (newline) begin
      col_d = '0;
      row_d = nl_row;
    end else if (cr_i)
      col_d = '0;
    else if (bs_i)
      col_d = col_q == 6'd0 ? col_q : col_q - 6'd1;
    else if (adv_i)
      col_d = col_q + 6'd1;
  end
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end
  assign col_o = col_q;
  assign row_o = row_q;
endmodule

// File: rtl/text_console.sv
// text_console: character-cell console writing a COLS x ROWS text VRAM, with clear, backspace and row overflow handling
// Ports: PixelClk clock; nRST sync active-low reset; ch (text_console_if.slave) character handshake;
//        v_ada/v_dina/v_wrea VRAM write-side address/data/enable; v_douta VRAM read data (1-cycle latency);
//        cursor_col/cursor_row cursor position; busy high outside IDLE.
// Macro TEXT_CONSOLE_SCROLL_EN: row overflow scrolls the screen up one row; undefined, the cursor wraps to row 0
// and only row 0 is cleared.
module text_console import console_pkg::*; #(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic               PixelClk,
  input  logic               nRST,
  text_console_if.slave      ch,
  output logic [VRAM_AW-1:0] v_ada,
  output logic [7:0]         v_dina,
  output logic               v_wrea,
  input  logic [7:0]         v_douta,
  output logic [5:0]         cursor_col,
  output logic [4:0]         cursor_row,
  output logic               busy
);
  localparam logic [VRAM_AW-1:0] LAST_CELL = VRAM_AW'(COLS * ROWS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [VRAM_AW-1:0] LAST_DST = VRAM_AW'((ROWS - 1) * COLS - 1);
  localparam logic [VRAM_AW-1:0] ROW_END  = LAST_CELL;
  localparam state_t             OVF_ST   = SCR_RD;
`else
  localparam logic [VRAM_AW-1:0] ROW_END  = VRAM_AW'(COLS - 1);
  localparam state_t             OVF_ST   = ROW_CLR;
  logic unused_douta;
  assign unused_douta = ^v_douta;
`endif
  state_t             state_q, state_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [7:0]         code_q, code_d;
  logic               adv_q, adv_d;
  logic               acc, printable, nl, cr, bs, adv, home, ovf;
  assign ch.ch_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign acc         = ch.ch_valid && ch.ch_ready;
  assign printable   = ch.ch_data >= 8'h20 && ch.ch_data != CH_DEL;
  assign nl          = acc && ch.ch_data == CH_LF;
  assign cr          = acc && ch.ch_data == CH_CR;
  // backspace at column 0 is swallowed: no move, no write
  assign bs          = acc && ch.ch_data == CH_BS && cursor_col != 6'd0;
  assign adv         = state_q == PUT && adv_q;
  assign home        = state_q == FULL_CLR && addr_q == LAST_CELL;
  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .adv_i    (adv),
    .nl_i     (nl),
    .cr_i     (cr),
    .bs_i     (bs),
    .home_i   (home),
    .col_o    (cursor_col),
    .row_o    (cursor_row),
    .ovf_o    (ovf)
  );
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state_q <= INIT_CLR;
      addr_q  <= '0;
      code_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      adv_q   <= adv_d;
    end
  end
  // addr_q is the absolute cell index for every sweep; overflow sweeps always start at cell 0
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    code_d  = code_q;
    adv_d   = adv_q;
    case (state_q)
      IDLE: if (acc) begin
        if (nl) begin
          state_d = ovf ? OVF_ST : IDLE;
          addr_d  = '0;
        end else if (ch.ch_data == CH_FF) begin
          state_d = FULL_CLR;
          addr_d  = '0;
        end else if (bs || printable) begin
          // backspace reuses PUT to blank the already-decremented position without advancing
          state_d = PUT;
          code_d  = bs ? BLANK : ch.ch_data;
          adv_d   = !bs;
        end
      end
      PUT: begin
        state_d = ovf ? OVF_ST : IDLE;
        addr_d  = '0;
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: state_d = SCR_WR;
      SCR_WR: begin
        state_d = addr_q == LAST_DST ? ROW_CLR : SCR_RD;
        addr_d  = addr_q + VRAM_AW'(1);
      end
`endif
      ROW_CLR: begin
        state_d = addr_q == ROW_END ? IDLE : ROW_CLR;
        addr_d  = addr_q + VRAM_AW'(1);
      end
      INIT_CLR, FULL_CLR: begin
        state_d = addr_q == LAST_CELL ? IDLE : state_q;
        addr_d  = addr_q + VRAM_AW'(1);
      end
      default: begin
        state_d = INIT_CLR;
        addr_d  = '0;
      end
    endcase
  end
  // reset gates the VRAM port combinationally so an abort never lets one more write through
  always_comb begin
    v_ada  = '0;
    v_dina = '0;
    v_wrea = 1'b0;
    case (state_q)
      INIT_CLR, FULL_CLR, ROW_CLR: begin
        v_ada  = addr_q;
        v_dina = BLANK;
        v_wrea = 1'b1;
      end
      PUT: begin
        v_ada  = cell_addr(cursor_row, cursor_col, COLS);
        v_dina = code_q;
        v_wrea = 1'b1;
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: v_ada = addr_q + VRAM_AW'(COLS);
      SCR_WR: begin
        v_ada  = addr_q;
        v_dina = v_douta;
        v_wrea = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!nRST) begin
      v_ada  = '0;
      v_dina = '0;
      v_wrea = 1'b0;
    end
  end
endmodule
